jtag_tap_ctrl: RTL and testbench
================================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_W, default 2, instruction register width (>=2).
REQ-002 SHALL have parameter NUM_CH, default 2, number of external scan channels; NUM_CH+2 <= 2**IR_W.
REQ-003 SHALL have parameter IDCODE, default 32'h0000_0001, device identification value; bit 0 always 1.
REQ-004 SHALL have port TCLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port TRST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port TMS  input  1  TAP mode select.
REQ-007 SHALL have port TDI  input  1  serial data in.
REQ-008 SHALL have port TDO  output  1  serial data out.
REQ-009 SHALL have port ch_tdo  input  NUM_CH  serial outputs of external chains.
REQ-010 SHALL have port ch_sel  output  NUM_CH  one-hot selected external chain.
REQ-011 SHALL have ports capture_dr, shift_dr, update_dr  output  1 each  DR strobes to chains.
REQ-012 SHALL have port test_mode  output  1  high when the active instruction selects a channel.
REQ-013 SHALL have port ir_out  output  IR_W  active instruction.
REQ-014 SHALL have port tap_state  output  4  current TAP state code.

Function
REQ-015 SHALL implement the 16-state IEEE 1149.1 TAP FSM, transitioning on the rising TCLK edge per TMS.
REQ-016 SHALL drive capture_dr/shift_dr/update_dr as Moore decodes, high exactly while in Capture-DR/Shift-DR/Update-DR.
REQ-017 SHALL load the IR shift register with {IR_W-2 zeros, 2'b01} on the edge leaving Capture-IR.
REQ-018 SHALL shift IR LSB-first on each edge in Shift-IR, TDI entering the MSB.
REQ-019 SHALL copy IR shift register to ir_out on the edge in Update-IR; ir_out is otherwise held.
REQ-020 SHALL decode ir_out: code k < NUM_CH selects channel k; code NUM_CH selects IDCODE; all other codes select BYPASS.
REQ-021 SHALL drive ch_sel one-hot for channel codes, all-zero otherwise; test_mode = |ch_sel.
REQ-022 SHALL load the 32-bit IDCODE register with IDCODE on Capture-DR and shift it LSB-first in Shift-DR when selected.
REQ-023 SHALL clear the 1-bit BYPASS register on Capture-DR and load TDI in Shift-DR when selected.
REQ-024 SHALL drive TDO combinationally: IR shift LSB in Shift-IR; selected DR serial output in Shift-DR; 0 in all other states.
REQ-025 SHALL return to Test-Logic-Reset after five consecutive TMS=1 edges from any state.
REQ-026 SHALL set ir_out to the IDCODE code on entering Test-Logic-Reset.
REQ-027 SHALL leave unselected DRs unchanged during Capture/Shift-DR.

Reset
REQ-028 SHALL, while TRST=0, force state Test-Logic-Reset, ir_out = IDCODE code, IR shift = 0, IDCODE shift = IDCODE, BYPASS = 0, all strobes 0, ch_sel = 0, TDO = 0, independent of TCLK.
REQ-029 SHALL abort any in-progress shift on TRST assertion with no Update strobe issued.

Structure
REQ-030 SHALL place the TAP state enum (4-bit encodings) and the IR capture constant in shared package jtag_pkg.
REQ-031 SHALL implement the FSM as sub-module jtag_tap_fsm (TCLK, TRST, TMS -> state); registers and muxing remain in jtag_tap_ctrl.

Verification
REQ-032 Assert TRST=0 for 3 TCLK, release -> tap_state=Test-Logic-Reset, ir_out=2'b10, ch_sel=2'b00, TDO=0.
REQ-033 From Shift-DR, drive TMS=1 for 5 edges -> Test-Logic-Reset reached on 5th edge, update_dr pulses once in passing, ir_out=2'b10.
REQ-034 Scan IR with TDI=2'b01 -> TDO emits 1 then 0 (capture pattern); after Update-IR ir_out=2'b01, ch_sel=2'b10, test_mode=1.
REQ-035 After reset, scan 32 DR bits -> TDO yields 32'h0000_0001 LSB-first.
REQ-036 IR=2'b11, shift 8 bits 10110010 through DR -> TDO repeats pattern delayed one TCLK, first bit 0.
REQ-037 IR=2'b00, ch_tdo[0] toggling during Shift-DR, TRST pulsed low mid-shift -> TDO follows ch_tdo[0] until reset, then 0; no update_dr, ir_out=2'b10.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions.
//   tap_state_e : IEEE 1149.1 TAP controller states with their standard 4-bit codes
//   IR_CAPTURE  : low bits loaded into the IR shift register in Capture-IR
//   dr_sel_e    : which data register the active instruction routes to TDO
package jtag_pkg;

    typedef enum logic [3:0] {
        StExit2Dr        = 4'h0,
        StExit1Dr        = 4'h1,
        StShiftDr        = 4'h2,
        StPauseDr        = 4'h3,
        StSelectIrScan   = 4'h4,
        StUpdateDr       = 4'h5,
        StCaptureDr      = 4'h6,
        StSelectDrScan   = 4'h7,
        StExit2Ir        = 4'h8,
        StExit1Ir        = 4'h9,
        StShiftIr        = 4'hA,
        StPauseIr        = 4'hB,
        StRunTestIdle    = 4'hC,
        StUpdateIr       = 4'hD,
        StCaptureIr      = 4'hE,
        StTestLogicReset = 4'hF
    } tap_state_e;

    // Upper IR bits are zero-extended by the user of this constant.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    typedef enum logic [1:0] {
        DrChannel,
        DrIdcode,
        DrBypass
    } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine.
//   TCLK       : clock, state advances on the rising edge
//   TRST       : asynchronous active-low reset to Test-Logic-Reset
//   TMS        : mode select steering the transitions
//   state      : current TAP state
//   state_next : state that will be entered on the next rising edge
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_e state,
    output tap_state_e state_next
);

    tap_state_e state_q, state_d;

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            state_q <= StTestLogicReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StTestLogicReset: state_d = TMS ? StTestLogicReset : StRunTestIdle;
            StRunTestIdle:    state_d = TMS ? StSelectDrScan   : StRunTestIdle;
            StSelectDrScan:   state_d = TMS ? StSelectIrScan   : StCaptureDr;
            StCaptureDr:      state_d = TMS ? StExit1Dr        : StShiftDr;
            StShiftDr:        state_d = TMS ? StExit1Dr        : StShiftDr;
            StExit1Dr:        state_d = TMS ? StUpdateDr       : StPauseDr;
            StPauseDr:        state_d = TMS ? StExit2Dr        : StPauseDr;
            StExit2Dr:        state_d = TMS ? StUpdateDr       : StShiftDr;
            StUpdateDr:       state_d = TMS ? StSelectDrScan   : StRunTestIdle;
            StSelectIrScan:   state_d = TMS ? StTestLogicReset : StCaptureIr;
            StCaptureIr:      state_d = TMS ? StExit1Ir        : StShiftIr;
            StShiftIr:        state_d = TMS ? StExit1Ir        : StShiftIr;
            StExit1Ir:        state_d = TMS ? StUpdateIr       : StPauseIr;
            StPauseIr:        state_d = TMS ? StExit2Ir        : StPauseIr;
            StExit2Ir:        state_d = TMS ? StUpdateIr       : StShiftIr;
            StUpdateIr:       state_d = TMS ? StSelectDrScan   : StRunTestIdle;
            default:          state_d = StTestLogicReset;
        endcase
    end

    assign state      = state_q;
    assign state_next = state_d;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller with IR, IDCODE and BYPASS registers and NUM_CH external scan chains.
//   TCLK, TRST       : clock and asynchronous active-low reset
//   TMS, TDI, TDO    : TAP mode select, serial in, serial out (TDO combinational)
//   ch_tdo, ch_sel   : serial returns of external chains / one-hot chain select
//   capture_dr, shift_dr, update_dr : DR phase strobes for the external chains
//   test_mode        : an external chain is selected by the active instruction
//   ir_out           : active instruction
//   tap_state        : current TAP state code
// Instruction codes: k < NUM_CH selects chain k, NUM_CH selects IDCODE, the rest BYPASS.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned IR_W   = 2,
    parameter int unsigned NUM_CH = 2,
    parameter logic [31:0] IDCODE = 32'h0000_0001
) (
    input  logic              TCLK,
    input  logic              TRST,
    input  logic              TMS,
    input  logic              TDI,
    output logic              TDO,
    input  logic [NUM_CH-1:0] ch_tdo,
    output logic [NUM_CH-1:0] ch_sel,
    output logic              capture_dr,
    output logic              shift_dr,
    output logic              update_dr,
    output logic              test_mode,
    output logic [IR_W-1:0]   ir_out,
    output logic [3:0]        tap_state
);

    localparam logic [IR_W-1:0] IrIdcode  = IR_W'(NUM_CH);
    localparam logic [IR_W-1:0] IrCapture = IR_W'(IR_CAPTURE);

    tap_state_e      state, state_next;
    logic [IR_W-1:0] ir_shift_q, ir_shift_d;
    logic [IR_W-1:0] ir_out_q, ir_out_d;
    logic [31:0]     idcode_q, idcode_d;
    logic            bypass_q, bypass_d;
    dr_sel_e         dr_sel;
    logic            chan_tdo;

    jtag_tap_fsm u_fsm (
        .TCLK       (TCLK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state),
        .state_next (state_next)
    );

    assign tap_state  = state;
    assign capture_dr = (state == StCaptureDr);
    assign shift_dr   = (state == StShiftDr);
    assign update_dr  = (state == StUpdateDr);
    assign ir_out     = ir_out_q;

    // Instruction decode
    always_comb begin
        ch_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            ch_sel[k] = (ir_out_q == IR_W'(k));
        end
        if (ir_out_q < IrIdcode) begin
            dr_sel = DrChannel;
        end else if (ir_out_q == IrIdcode) begin
            dr_sel = DrIdcode;
        end else begin
            dr_sel = DrBypass;
        end
    end

    assign test_mode = |ch_sel;
    assign chan_tdo  = |(ch_tdo & ch_sel);

    // Register next-state
    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_out_d   = ir_out_q;
        idcode_d   = idcode_q;
        bypass_d   = bypass_q;
        case (state)
            StCaptureIr: ir_shift_d = IrCapture;
            StShiftIr:   ir_shift_d = {TDI, ir_shift_q[IR_W-1:1]};
            StUpdateIr:  ir_out_d   = ir_shift_q;
            StCaptureDr: begin
                if (dr_sel == DrIdcode) idcode_d = IDCODE;
                if (dr_sel == DrBypass) bypass_d = 1'b0;
            end
            StShiftDr: begin
                if (dr_sel == DrIdcode) idcode_d = {TDI, idcode_q[31:1]};
                if (dr_sel == DrBypass) bypass_d = TDI;
            end
            default: ;
        endcase
        // Looking at the next state makes ir_out valid on the same edge that enters TLR.
        if (state_next == StTestLogicReset) begin
            ir_out_d = IrIdcode;
        end
    end

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            ir_shift_q <= '0;
            ir_out_q   <= IrIdcode;
            idcode_q   <= IDCODE;
            bypass_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_out_q   <= ir_out_d;
            idcode_q   <= idcode_d;
            bypass_q   <= bypass_d;
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state == StShiftIr) begin
            TDO = ir_shift_q[0];
        end else if (state == StShiftDr) begin
            case (dr_sel)
                DrChannel: TDO = chan_tdo;
                DrIdcode:  TDO = idcode_q[0];
                default:   TDO = bypass_q;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: FSM walk table plus scan sequences with a TDO scoreboard.
module tb_jtag_tap_ctrl;

    localparam int unsigned IR_W   = 2;
    localparam int unsigned NUM_CH = 2;
    localparam logic [31:0] IDCODE = 32'h0000_0001;

    logic              TCLK, TRST, TMS, TDI, TDO;
    logic [NUM_CH-1:0] ch_tdo, ch_sel, ch_next;
    logic              capture_dr, shift_dr, update_dr, test_mode;
    logic [IR_W-1:0]   ir_out;
    logic [3:0]        tap_state;

    int n_checks = 0;
    int n_err    = 0;
    int udr_count = 0;

    typedef struct {
        string name;
        logic  exp;
    } sb_item_t;
    sb_item_t sb_q[$];

    typedef struct packed {
        logic       tms;
        logic [3:0] st;
    } fsm_vec_t;
    fsm_vec_t fsm_tbl[$];

    jtag_tap_ctrl #(
        .IR_W   (IR_W),
        .NUM_CH (NUM_CH),
        .IDCODE (IDCODE)
    ) dut (
        .TCLK       (TCLK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO),
        .ch_tdo     (ch_tdo),
        .ch_sel     (ch_sel),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .test_mode  (test_mode),
        .ir_out     (ir_out),
        .tap_state  (tap_state)
    );

    initial begin
        TCLK = 1'b0;
        forever #5 TCLK = ~TCLK;
    end

    // Counts cycles spent in Update-DR (value seen just before each edge).
    always @(posedge TCLK) begin
        if (update_dr) udr_count <= udr_count + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_tdo(input string name, input logic b);
        sb_item_t it;
        it.name = name;
        it.exp  = b;
        sb_q.push_back(it);
    endtask

    // One TCLK: inputs change on the falling edge, TDO optionally sampled before the rising edge.
    task automatic step(input logic tms, input logic tdi, input bit sample);
        sb_item_t it;
        @(negedge TCLK);
        TMS    = tms;
        TDI    = tdi;
        ch_tdo = ch_next;
        #1;
        if (sample) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL scoreboard: actual=empty required=entry");
            end else begin
                it = sb_q.pop_front();
                check(it.name, 32'(TDO), 32'(it.exp));
            end
        end
        @(posedge TCLK);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge TCLK);
        TMS  = 1'b1;
        TRST = 1'b0;
        repeat (3) @(posedge TCLK);
        #1;
        @(negedge TCLK);
        TRST = 1'b1;
        @(posedge TCLK);
        #1;
    endtask

    // From Run-Test/Idle: scan code into IR, checking the capture pattern on TDO; ends in RTI.
    task automatic load_ir(input logic [IR_W-1:0] code);
        for (int i = 0; i < int'(IR_W); i++) begin
            expect_tdo($sformatf("ir_capture_bit%0d", i), (i == 0));
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < int'(IR_W); i++) begin
            step((i == int'(IR_W) - 1), code[i], 1'b1);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_vec(input logic tms, input logic [3:0] st);
        fsm_tbl.push_back({tms, st});
    endtask

    initial begin
        logic [63:0] data;
        logic [31:0] id_v;
        logic [7:0]  pat;
        logic [3:0]  exp_st[5];
        int          udr_base;
        logic        b;

        TRST    = 1'b1;
        TMS     = 1'b1;
        TDI     = 1'b0;
        ch_tdo  = '0;
        ch_next = '0;
        id_v    = IDCODE;

        // Reset: asynchronous, then held for 3 clocks
        #2 TRST = 1'b0;
        #1;
        check("async_reset_state", 32'(tap_state), 32'hF);
        repeat (3) @(posedge TCLK);
        #1;
        check("reset_state", 32'(tap_state), 32'hF);
        check("reset_ir_out", 32'(ir_out), 32'h2);
        check("reset_ch_sel", 32'(ch_sel), 32'h0);
        check("reset_tdo", 32'(TDO), 32'h0);
        check("reset_strobes", 32'({capture_dr, shift_dr, update_dr, test_mode}), 32'h0);
        @(negedge TCLK);
        TRST = 1'b1;
        @(posedge TCLK);
        #1;
        check("post_reset_state", 32'(tap_state), 32'hF);
        check("post_reset_ir_out", 32'(ir_out), 32'h2);

        // FSM walk covering all 16 states
        add_vec(1'b0, 4'hC); add_vec(1'b1, 4'h7); add_vec(1'b0, 4'h6); add_vec(1'b0, 4'h2);
        add_vec(1'b1, 4'h1); add_vec(1'b0, 4'h3); add_vec(1'b1, 4'h0); add_vec(1'b0, 4'h2);
        add_vec(1'b1, 4'h1); add_vec(1'b1, 4'h5); add_vec(1'b1, 4'h7); add_vec(1'b1, 4'h4);
        add_vec(1'b0, 4'hE); add_vec(1'b0, 4'hA); add_vec(1'b1, 4'h9); add_vec(1'b0, 4'hB);
        add_vec(1'b1, 4'h8); add_vec(1'b0, 4'hA); add_vec(1'b1, 4'h9); add_vec(1'b1, 4'hD);
        add_vec(1'b0, 4'hC); add_vec(1'b1, 4'h7); add_vec(1'b1, 4'h4); add_vec(1'b1, 4'hF);
        add_vec(1'b1, 4'hF); add_vec(1'b0, 4'hC); add_vec(1'b0, 4'hC); add_vec(1'b1, 4'h7);
        add_vec(1'b0, 4'h6); add_vec(1'b1, 4'h1); add_vec(1'b0, 4'h3); add_vec(1'b0, 4'h3);
        add_vec(1'b1, 4'h0); add_vec(1'b1, 4'h5); add_vec(1'b0, 4'hC);
        foreach (fsm_tbl[i]) begin
            step(fsm_tbl[i].tms, 1'b0, 1'b0);
            check($sformatf("fsm_row%0d_state", i), 32'(tap_state), 32'(fsm_tbl[i].st));
            check($sformatf("fsm_row%0d_strobes", i), 32'({capture_dr, shift_dr, update_dr}),
                  32'({fsm_tbl[i].st == 4'h6, fsm_tbl[i].st == 4'h2, fsm_tbl[i].st == 4'h5}));
        end

        // IDCODE after reset, then the TDI bits reappear 32 shifts later
        apply_reset();
        step(1'b0, 1'b0, 1'b0);
        data = {$urandom(), $urandom()};
        for (int i = 0; i < 32; i++) expect_tdo($sformatf("idcode_bit%0d", i), id_v[i]);
        for (int i = 32; i < 64; i++) expect_tdo($sformatf("idcode_echo%0d", i), data[i-32]);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) step((i == 63), data[i], 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Select channel 1; TDO must follow ch_tdo[1], not ch_tdo[0]
        load_ir(2'b01);
        check("ch1_ir_out", 32'(ir_out), 32'h1);
        check("ch1_ch_sel", 32'(ch_sel), 32'h2);
        check("ch1_test_mode", 32'(test_mode), 32'h1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            b       = 1'($urandom_range(0, 1));
            ch_next = {b, ~b};
            expect_tdo($sformatf("ch1_tdo%0d", i), b);
            step((i == 5), 1'b0, 1'b1);
        end
        ch_next = '0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // BYPASS: pattern comes back one clock late, first bit is the captured 0
        load_ir(2'b11);
        check("byp_ch_sel", 32'(ch_sel), 32'h0);
        check("byp_test_mode", 32'(test_mode), 32'h0);
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            expect_tdo($sformatf("byp_bit%0d", i), (i == 0) ? 1'b0 : pat[i-1]);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step((i == 7), pat[i], 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Five TMS=1 edges from Shift-DR with BYPASS active
        load_ir(2'b11);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("tms5_start_state", 32'(tap_state), 32'h2);
        exp_st   = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};
        udr_base = udr_count;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("tms5_edge%0d_state", i), 32'(tap_state), 32'(exp_st[i]));
        end
        check("tms5_update_pulses", 32'(udr_count - udr_base), 32'h1);
        check("tms5_ir_out", 32'(ir_out), 32'h2);

        // Five TMS=1 edges from Shift-IR
        step(1'b0, 1'b0, 1'b0);
        load_ir(2'b01);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("shir_start_state", 32'(tap_state), 32'hA);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check("shir_tlr_state", 32'(tap_state), 32'hF);
        check("shir_tlr_ir_out", 32'(ir_out), 32'h2);
        step(1'b0, 1'b0, 1'b0);

        // Channel 0 shift aborted by TRST
        load_ir(2'b00);
        check("ch0_ch_sel", 32'(ch_sel), 32'h1);
        udr_base = udr_count;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            b       = 1'(i & 1);
            ch_next = {~b, b};
            expect_tdo($sformatf("ch0_tdo%0d", i), b);
            step(1'b0, 1'b0, 1'b1);
        end
        check("abort_pre_state", 32'(tap_state), 32'h2);
        @(negedge TCLK);
        ch_tdo = 2'b01;
        #2 TRST = 1'b0;
        #1;
        check("abort_tdo", 32'(TDO), 32'h0);
        check("abort_state", 32'(tap_state), 32'hF);
        check("abort_shift_dr", 32'(shift_dr), 32'h0);
        check("abort_ir_out", 32'(ir_out), 32'h2);
        check("abort_ch_sel", 32'(ch_sel), 32'h0);
        TMS = 1'b0;
        repeat (2) @(posedge TCLK);
        #1;
        check("abort_hold_state", 32'(tap_state), 32'hF);
        @(negedge TCLK);
        TRST = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("abort_rti_state", 32'(tap_state), 32'hC);
        check("abort_no_update", 32'(udr_count - udr_base), 32'h0);
        check("abort_final_ir_out", 32'(ir_out), 32'h2);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
